// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding req/ack
// reads to instruction memory and presents buffered {pc,instruction} pairs to IF/ID.
module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_hazerd,
    input  logic            flush_flag,
    input  logic [XLEN-1:0] flush_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instruction_out,
    output logic            fetch_valid
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] pc_mem  [FIFO_DEPTH];
    logic [XLEN-1:0] ins_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [PW:0]     count_nxt;
    logic            push;
    logic            pop;
    logic            unused_bits;

    assign unused_bits = &{1'b0, flush_pc[1:0]};

    // Flush overrides both the pop and the push of the same cycle.
    assign fetch_valid = (count != '0);
    assign pop         = fetch_valid && !load_hazerd && !flush_flag;
    assign push        = (state == REQ) && imem_ack && !flush_flag;
    assign count_nxt   = count + (PW+1)'(push) - (PW+1)'(pop);

    assign imem_req        = (state != IDLE);
    assign imem_addr       = (state == REQ)   ? fetch_pc :
                             (state == DRAIN) ? drain_addr : '0;
    assign pc_out          = fetch_valid ? pc_mem[rd_ptr]  : '0;
    assign instruction_out = fetch_valid ? ins_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (flush_flag) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= {flush_pc[XLEN-1:2], 2'b00};
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]  <= fetch_pc;
                    ins_mem[wr_ptr] <= imem_rdata;
                    wr_ptr          <= wr_ptr + PW'(1);
                    fetch_pc        <= fetch_pc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_nxt;
            end

            case (state)
                IDLE:
                    if (!flush_flag && count < DEPTH_C)
                        state <= REQ;
                REQ:
                    if (imem_ack) begin
                        if (flush_flag || count_nxt >= DEPTH_C)
                            state <= IDLE;
                    end else if (flush_flag) begin
                        // Address must stay on the bus until the orphaned read acks.
                        state      <= DRAIN;
                        drain_addr <= fetch_pc;
                    end
                DRAIN:
                    if (imem_ack)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable instruction memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_hazerd;
    logic        flush_flag;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int vectors = 0;
    int errors  = 0;
    int lat     = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .load_hazerd     (load_hazerd),
        .flush_flag      (flush_flag),
        .flush_pc        (flush_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid)
    );

    always #5 clk = ~clk;

    // Memory: ack after 'lat' wait cycles of a held request.
    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = imem_addr ^ KEY;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_ins"}, instruction_out, pc ^ KEY);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_ins"}, instruction_out, 32'd0);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        chk({tag, "_addr"}, imem_addr, a);
    endtask

    // Consume every presented word in order against the queued expectations.
    task automatic sb_run(input string tag, input int budget);
        int cyc = 0;
        logic [31:0] e;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            if (fetch_valid) begin
                e = exp_q.pop_front();
                chk({tag, "_pc"}, pc_out, e);
                chk({tag, "_ins"}, instruction_out, e ^ KEY);
            end
            cyc++;
        end
        if (exp_q.size() > 0) begin
            chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b0; load_hazerd = 1'b0; flush_flag = 1'b0; flush_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_req("rst", 1'b0, 32'd0);
        chk_bubble("rst");
        rst = 1'b1;

        // Zero-wait streaming
        @(negedge clk); chk_req("first_req", 1'b1, 32'd0); chk("first_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk); chk_word("s0", 32'd0);
        @(negedge clk); chk_word("s4", 32'd4);
        @(negedge clk); chk_word("s8", 32'd8);
        load_hazerd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_word("stall", 32'd8);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        load_hazerd = 1'b0;
        exp_q.push_back(32'd12); exp_q.push_back(32'd16); exp_q.push_back(32'd20);
        sb_run("release", 20);

        // Re-reset, then flush to a misaligned target while pc_out=4
        rst = 1'b0;
        @(negedge clk); chk_req("rst2", 1'b0, 32'd0); chk_bubble("rst2");
        rst = 1'b1;
        @(negedge clk); chk_req("rst2_req", 1'b1, 32'd0);
        @(negedge clk); chk_word("f0", 32'd0);
        @(negedge clk); chk_word("f4", 32'd4);
        flush_flag = 1'b1; flush_pc = 32'h0000_0103;
        @(negedge clk); chk_bubble("flush"); chk("flush_req", {31'd0, imem_req}, 32'd0);
        flush_flag = 1'b0;
        @(negedge clk); chk_req("redir", 1'b1, 32'h100); chk("redir_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk); chk_word("r100", 32'h100);
        @(negedge clk); chk_word("r104", 32'h104);

        // Flush together with stall, target near the top of the address space
        load_hazerd = 1'b1; flush_flag = 1'b1; flush_pc = 32'hFFFF_FFF8;
        @(negedge clk); chk_bubble("flush_stall");
        load_hazerd = 1'b0; flush_flag = 1'b0;
        @(negedge clk); chk_req("wrap_req", 1'b1, 32'hFFFF_FFF8);
        @(negedge clk); chk_word("wrap0", 32'hFFFF_FFF8);
        @(negedge clk); chk_word("wrap1", 32'hFFFF_FFFC);
        @(negedge clk); chk_word("wrap2", 32'h0000_0000);

        // Two-wait memory, flush in the first wait cycle
        rst = 1'b0; lat = 2;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); chk_req("lat_req", 1'b1, 32'd0);
        flush_flag = 1'b1; flush_pc = 32'h0000_0040;
        @(negedge clk); flush_flag = 1'b0; chk_req("drain1", 1'b1, 32'd0);
        @(negedge clk); chk_req("drain2", 1'b1, 32'd0); chk("drain2_ack", {31'd0, imem_ack}, 32'd1);
        @(negedge clk); chk("drain_done", {31'd0, imem_req}, 32'd0); chk_bubble("drain_done");
        @(negedge clk); chk_req("lat_redir", 1'b1, 32'h40);
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        sb_run("lat", 30);

        // Reset during a request wait cycle
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req && !imem_ack) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_cycle_found", {31'd0, found}, 32'd1);
        rst = 1'b0;
        @(negedge clk); chk_req("rst_mid", 1'b0, 32'd0); chk_bubble("rst_mid");
        lat = 0; rst = 1'b1;
        @(negedge clk); chk_req("rst_mid_req", 1'b1, 32'd0);
        @(negedge clk); chk_word("rst_mid_w0", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
